arb_n_af_avlstrm: RTL and testbench

ARB_N_AF_AVLSTRM -- requirements
Module: arb_n_af_avlstrm

---
 rtl/struct_s_pkg.sv | 6 +
 rtl/arb_n_af_avlstrm_fifo_slice.sv | 53 +++++
 rtl/arb_n_af_avlstrm.sv | 89 ++++++++
 tb/tb_arb_n_af_avlstrm.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/struct_s_pkg.sv
// struct_s: shared types and widths for the N-input arbitrated stream block
// Holds the arbitration mode enum and the default payload width.
package struct_s;
  localparam int META_WIDTH = 8;
  typedef enum logic {ARB_RR, ARB_PRIO} arb_mode_e;
endpackage

// File: rtl/arb_n_af_avlstrm_fifo_slice.sv
// arb_fifo_slice: per-channel show-ahead FIFO with occupancy and almost-full flag
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, wdata  write strobe and payload; ignored while full
//   pop          remove head; ignored while empty
//   head         current head item (show-ahead)
//   empty, full  occupancy == 0 / == DEPTH
//   almost_full  registered, occupancy >= FULL_LEVEL after this edge's push/pop
//   occ          current occupancy
module arb_fifo_slice import struct_s::*; #(
  parameter int DWIDTH = META_WIDTH,
  parameter int DEPTH = 512,
  parameter int FULL_LEVEL = 480,
  localparam int AW = $clog2(DEPTH),
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] head,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [OW-1:0]     occ
);
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  logic [OW-1:0] occ_nxt;
  // full is judged before the pop, so a full slice drops even when drained this cycle
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign occ_nxt = occ + OW'(do_push) - OW'(do_pop);
  assign empty = occ == '0;
  assign full = occ == OW'(DEPTH);
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
      almost_full <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      occ <= occ_nxt;
      almost_full <= occ_nxt >= OW'(FULL_LEVEL);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/arb_n_af_avlstrm.sv
// arb_n_af_avlstrm: N buffered input channels arbitrated onto one registered stream
// Ports:
//   Clk, Rst_n       clock, asynchronous active-low reset
//   in_data/valid    per-channel payload and write strobe (no ready)
//   in_almost_full   per-channel registered backpressure
//   out_data/chan    granted payload and its source channel
//   out_valid/ready  output handshake
//   stats_*_cnt      accepted-output and dropped-input counters (wrap at 2^32)
module arb_n_af_avlstrm import struct_s::*; #(
  parameter int NUM_IN = 4,
  parameter int DWIDTH = META_WIDTH,
  parameter int DEPTH = 512,
  parameter int FULL_LEVEL = 480,
  parameter arb_mode_e ARB_MODE = ARB_RR,
  localparam int CW = $clog2(NUM_IN)
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [NUM_IN*DWIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_almost_full,
  output logic [DWIDTH-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CW-1:0]            out_chan,
  output logic [31:0]              stats_out_cnt,
  output logic [31:0]              stats_drop_cnt
);
  localparam int OW = $clog2(DEPTH + 1);
  logic [NUM_IN-1:0] empty, full, pop;
  logic [DWIDTH-1:0] head [NUM_IN];
  logic [OW-1:0] occ [NUM_IN];
  logic [CW-1:0] rr_ptr, win;
  logic found, load;
  logic [31:0] drops;
  int idx;
  for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
    arb_fifo_slice #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .FULL_LEVEL(FULL_LEVEL)) u_fifo (
      .clk(Clk),
      .rst_n(Rst_n),
      .push(in_valid[i] & ~full[i]),
      .pop(pop[i]),
      .wdata(in_data[i*DWIDTH +: DWIDTH]),
      .head(head[i]),
      .empty(empty[i]),
      .full(full[i]),
      .almost_full(in_almost_full[i]),
      .occ(occ[i])
    );
  end
  // scan starts at rr_ptr in round-robin mode, at 0 in priority mode
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = (ARB_MODE == ARB_RR ? int'(rr_ptr) : 0) + k;
      idx = idx >= NUM_IN ? idx - NUM_IN : idx;
      if (!found && !empty[idx]) begin
        found = 1'b1;
        win = CW'(idx);
      end
    end
  end
  always_comb begin
    drops = '0;
    for (int k = 0; k < NUM_IN; k++) drops = drops + 32'(in_valid[k] && occ[k] == OW'(DEPTH));
  end
  assign load = ~out_valid | out_ready;
  assign pop = (load && found) ? NUM_IN'(1) << win : '0;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_chan <= '0;
      rr_ptr <= '0;
      stats_out_cnt <= '0;
      stats_drop_cnt <= '0;
    end else begin
      if (load) out_valid <= found;
      if (load && found) begin
        out_data <= head[win];
        out_chan <= win;
        rr_ptr <= win == CW'(NUM_IN - 1) ? '0 : win + 1'b1;
      end
      if (out_valid && out_ready) stats_out_cnt <= stats_out_cnt + 32'd1;
      stats_drop_cnt <= stats_drop_cnt + drops;
    end
endmodule

// File: tb/tb_arb_n_af_avlstrm.sv
// tb_arb_n_af_avlstrm: directed vector and sequence bench for arb_n_af_avlstrm
module tb_arb_n_af_avlstrm;
  import struct_s::*;
  logic Clk = 1'b0, Rst_n = 1'b1, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0] in_valid = '0;
  logic [3:0] r_af, p_af;
  logic [7:0] r_od, p_od;
  logic r_ov, p_ov;
  logic [1:0] r_oc, p_oc;
  logic [31:0] r_ocnt, r_dcnt, p_ocnt, p_dcnt;
  int checks = 0, failures = 0;
  logic sb_en = 1'b0;
  logic [7:0] q [4][$];

  always #5 Clk = ~Clk;

  arb_n_af_avlstrm #(.NUM_IN(4), .DWIDTH(8), .DEPTH(8), .FULL_LEVEL(6), .ARB_MODE(ARB_RR)) dut_r (
    .Clk(Clk), .Rst_n(Rst_n), .in_data(in_data), .in_valid(in_valid), .in_almost_full(r_af),
    .out_data(r_od), .out_valid(r_ov), .out_ready(out_ready), .out_chan(r_oc),
    .stats_out_cnt(r_ocnt), .stats_drop_cnt(r_dcnt));

  arb_n_af_avlstrm #(.NUM_IN(4), .DWIDTH(8), .DEPTH(16), .FULL_LEVEL(12), .ARB_MODE(ARB_PRIO)) dut_p (
    .Clk(Clk), .Rst_n(Rst_n), .in_data(in_data), .in_valid(in_valid), .in_almost_full(p_af),
    .out_data(p_od), .out_valid(p_ov), .out_ready(out_ready), .out_chan(p_oc),
    .stats_out_cnt(p_ocnt), .stats_drop_cnt(p_dcnt));

  typedef struct {
    logic [31:0] d;
    logic [3:0] v;
    logic rdy, pr, ev;
    logic [1:0] ec;
    logic [7:0] ed;
    logic [31:0] ecnt;
  } vec_t;
  vec_t tv [21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // one clock; scoreboards the RR instance before the edge, checks stall hold after it
  task automatic cyc();
    logic stall;
    logic [7:0] sd;
    logic [1:0] sc;
    stall = sb_en && r_ov && !out_ready;
    sd = r_od;
    sc = r_oc;
    if (sb_en && r_ov && out_ready) begin
      if (q[r_oc].size() == 0) chk("sb_extra_item", {24'd0, r_od}, 32'hFFFF_FFFF);
      else chk("sb_order", {24'd0, r_od}, {24'd0, q[r_oc].pop_front()});
    end
    @(posedge Clk);
    #1;
    if (stall) begin
      chk("hold_valid", r_ov, 1);
      chk("hold_data", r_od, sd);
      chk("hold_chan", r_oc, sc);
    end
  endtask

  task automatic do_reset();
    in_valid = '0;
    Rst_n = 1'b0;
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    for (int c = 0; c < 4; c++) q[c].delete();
  endtask

  function automatic int qleft();
    return q[0].size() + q[1].size() + q[2].size() + q[3].size();
  endfunction

  initial begin
    logic seen;
    for (int n = 0; n < 6; n++) begin
      tv[n].d = 32'hC181_4101;
      tv[n].v = n == 0 ? 4'hF : 4'h0;
      tv[n].rdy = 1'b1;
      tv[n].pr = 1'b0;
      tv[n].ev = n >= 1 && n <= 4;
      tv[n].ec = 2'(n - 1);
      tv[n].ed = {2'(n - 1), 6'd1};
      tv[n].ecnt = n <= 1 ? 0 : 32'(n - 1);
    end
    for (int j = 0; j < 15; j++) begin
      tv[j+6].d = {24'hC18141, 8'(j)};
      tv[j+6].v = j == 0 ? 4'hF : (j < 10 ? 4'h1 : 4'h0);
      tv[j+6].rdy = 1'b1;
      tv[j+6].pr = 1'b1;
      tv[j+6].ev = j >= 1 && j <= 13;
      tv[j+6].ec = j <= 10 ? 2'd0 : 2'(j - 10);
      tv[j+6].ed = j <= 10 ? 8'(j - 1) : {2'(j - 10), 6'd1};
      tv[j+6].ecnt = j <= 1 ? 0 : 32'(j - 1);
    end
    #2 Rst_n = 1'b0;
    #1;
    chk("rst_ov", r_ov, 0);
    chk("rst_od", r_od, 0);
    chk("rst_oc", r_oc, 0);
    chk("rst_af", r_af, 0);
    chk("rst_ocnt", r_ocnt, 0);
    chk("rst_dcnt", r_dcnt, 0);
    chk("rst_p_ov", p_ov, 0);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    // round-robin fan-in, then priority starvation
    for (int n = 0; n < 21; n++) begin
      if (n == 6) do_reset();
      in_data = tv[n].d;
      in_valid = tv[n].v;
      out_ready = tv[n].rdy;
      cyc();
      chk($sformatf("tv%0d_valid", n), tv[n].pr ? p_ov : r_ov, tv[n].ev);
      if (tv[n].ev) begin
        chk($sformatf("tv%0d_chan", n), tv[n].pr ? p_oc : r_oc, tv[n].ec);
        chk($sformatf("tv%0d_data", n), tv[n].pr ? p_od : r_od, tv[n].ed);
      end
      chk($sformatf("tv%0d_ocnt", n), tv[n].pr ? p_ocnt : r_ocnt, tv[n].ecnt);
    end
    // fill channel 2 with the output stalled: 1 in stage + 8 buffered, rest dropped
    do_reset();
    sb_en = 1'b1;
    out_ready = 1'b0;
    for (int w = 1; w <= 11; w++) begin
      in_valid = 4'b0100;
      in_data[23:16] = {2'd2, 6'(w)};
      if (w <= 9) q[2].push_back({2'd2, 6'(w)});
      cyc();
      if (w == 2) begin
        chk("fill_ov", r_ov, 1);
        chk("fill_head", r_od, 8'h81);
      end
      if (w == 6) chk("af_before", r_af, 4'b0000);
      if (w == 7) chk("af_at_level", r_af, 4'b0100);
      if (w == 9) chk("drop_none", r_dcnt, 0);
      if (w == 10) chk("drop_one", r_dcnt, 1);
      if (w == 11) chk("drop_two", r_dcnt, 2);
    end
    in_valid = '0;
    // drop counter wrap
    force dut_r.stats_drop_cnt = 32'hFFFF_FFFF;
    #1;
    release dut_r.stats_drop_cnt;
    chk("drop_preload", r_dcnt, 32'hFFFF_FFFF);
    in_valid = 4'b0100;
    cyc();
    in_valid = '0;
    chk("drop_wrap", r_dcnt, 0);
    out_ready = 1'b1;
    for (int t = 0; t < 30 && qleft() != 0; t++) cyc();
    chk("drain_left", qleft(), 0);
    chk("drain_ov", r_ov, 0);
    chk("drain_ocnt", r_ocnt, 9);
    chk("drain_af", r_af, 0);
    // alternating ready with one write per cycle across channels
    for (int t = 0; t < 40; t++) begin
      out_ready = t % 2 == 0;
      in_valid = '0;
      if (t < 16) begin
        in_valid[t % 4] = 1'b1;
        in_data[(t % 4) * 8 +: 8] = {2'(t % 4), 6'(t)};
        q[t % 4].push_back({2'(t % 4), 6'(t)});
      end
      cyc();
    end
    in_valid = '0;
    out_ready = 1'b1;
    for (int t = 0; t < 20 && qleft() != 0; t++) cyc();
    chk("toggle_left", qleft(), 0);
    chk("toggle_ocnt", r_ocnt, 25);
    // reset mid-stream with five items held
    sb_en = 1'b0;
    out_ready = 1'b0;
    for (int w = 0; w < 6; w++) begin
      in_valid = 4'b0010;
      in_data[15:8] = {2'd1, 6'(w)};
      cyc();
    end
    in_valid = '0;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("pre_rst_ocnt", r_ocnt, 26);
    #2 Rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", r_ov, 0);
    chk("mid_rst_ocnt", r_ocnt, 0);
    chk("mid_rst_dcnt", r_dcnt, 0);
    chk("mid_rst_od", r_od, 0);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 6; t++) begin
      cyc();
      seen |= r_ov;
    end
    chk("no_stale", seen, 0);
    in_valid = 4'b1000;
    in_data[31:24] = 8'hE5;
    cyc();
    in_valid = '0;
    chk("post_rst_lat1", r_ov, 0);
    cyc();
    chk("post_rst_ov", r_ov, 1);
    chk("post_rst_od", r_od, 8'hE5);
    chk("post_rst_oc", r_oc, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end
endmodule
